// File: rtl/tick_scheduler.sv
// tick_scheduler: a free-running prescaler that produces a base tick every
// BASE_DIV clocks, four independently configurable channels that count base
// ticks and emit one-cycle Tick pulses (periodic or one-shot), and a small
// three-state configuration handshake (IDLE -> APPLY -> ACK).
//
// Configuration writes are applied only in cycles where BaseTick is low, so
// a write never competes with a channel advance in the same clock edge.

module tick_scheduler #(
   parameter int BASE_DIV    = 100000,
   parameter int BASE_BITS   = 17,
   parameter int PERIOD_BITS = 10
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   CfgValid,
   output logic                   CfgReady,
   input  logic [1:0]             CfgChan,
   input  logic [PERIOD_BITS-1:0] CfgPeriod,
   input  logic                   CfgMode,
   input  logic                   CfgEnable,
   output logic                   BaseTick,
   output logic [3:0]             Tick,
   output logic [3:0]             Busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_ACK   = 2'd2
   } cfg_state_e;

   localparam logic [BASE_BITS-1:0]   PRE_LAST = BASE_BITS'(BASE_DIV - 1);
   localparam logic [BASE_BITS-1:0]   PRE_ONE  = BASE_BITS'(1);
   localparam logic [PERIOD_BITS-1:0] PER_ONE  = PERIOD_BITS'(1);

   // Prescaler
   logic [BASE_BITS-1:0]   pre_cnt_q, pre_cnt_d;
   logic                   base_tick_q, base_tick_d;

   // Configuration handshake
   cfg_state_e             state_q, state_d;
   logic                   ready_q, ready_d;
   logic [1:0]             cap_chan_q, cap_chan_d;
   logic [PERIOD_BITS-1:0] cap_period_q, cap_period_d;
   logic                   cap_mode_q, cap_mode_d;
   logic                   cap_enable_q, cap_enable_d;
   logic                   write_s;

   // Channel state
   logic [3:0][PERIOD_BITS-1:0] per_q, per_d;
   logic [3:0][PERIOD_BITS-1:0] cnt_q, cnt_d;
   logic [3:0]                  mode_q, mode_d;
   logic [3:0]                  busy_q, busy_d;
   logic [3:0]                  tick_q, tick_d;

   // Prescaler: count 0..BASE_DIV-1 and flag the wrap as next cycle's BaseTick
   always_comb begin
      pre_cnt_d   = pre_cnt_q;
      base_tick_d = 1'b0;
      if (pre_cnt_q == PRE_LAST) begin
         pre_cnt_d   = '0;
         base_tick_d = 1'b1;
      end else begin
         pre_cnt_d   = pre_cnt_q + PRE_ONE;
         base_tick_d = 1'b0;
      end
   end

   // Configuration FSM: capture on accept, write when BaseTick is low, then ack
   always_comb begin
      state_d      = state_q;
      cap_chan_d   = cap_chan_q;
      cap_period_d = cap_period_q;
      cap_mode_d   = cap_mode_q;
      cap_enable_d = cap_enable_q;
      write_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // ready_q is low in the first cycle after reset, so this also
            // keeps requests raised during reset from being taken.
            if (ready_q && CfgValid) begin
               cap_chan_d   = CfgChan;
               cap_period_d = CfgPeriod;
               cap_mode_d   = CfgMode;
               cap_enable_d = CfgEnable;
               state_d      = ST_APPLY;
            end else begin
               state_d      = ST_IDLE;
            end
         end
         ST_APPLY: begin
            if (!base_tick_q) begin
               write_s = 1'b1;
               state_d = ST_ACK;
            end else begin
               // A channel may advance this edge; defer the write by a cycle.
               write_s = 1'b0;
               state_d = ST_APPLY;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // Channels: apply a pending write, otherwise advance on BaseTick while armed
   always_comb begin
      per_d  = per_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      busy_d = busy_q;
      tick_d = 4'b0000;
      for (int ch = 0; ch < 4; ch++) begin
         if (write_s && (cap_chan_q == 2'(ch))) begin
            per_d[ch]  = cap_period_q;
            mode_d[ch] = cap_mode_q;
            cnt_d[ch]  = '0;
            busy_d[ch] = cap_enable_q && (cap_period_q != '0);
         end else if (base_tick_q && busy_q[ch]) begin
            if (cnt_q[ch] == (per_q[ch] - PER_ONE)) begin
               cnt_d[ch]  = '0;
               tick_d[ch] = 1'b1;
               // One-shot channels disarm in the same edge that schedules the tick.
               busy_d[ch] = ~mode_q[ch];
            end else begin
               cnt_d[ch]  = cnt_q[ch] + PER_ONE;
            end
         end else begin
            cnt_d[ch] = cnt_q[ch];
         end
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge Clock) begin
      if (Reset) begin
         pre_cnt_q    <= '0;
         base_tick_q  <= 1'b0;
         state_q      <= ST_IDLE;
         ready_q      <= 1'b0;
         cap_chan_q   <= 2'd0;
         cap_period_q <= '0;
         cap_mode_q   <= 1'b0;
         cap_enable_q <= 1'b0;
         per_q        <= '0;
         cnt_q        <= '0;
         mode_q       <= 4'b0000;
         busy_q       <= 4'b0000;
         tick_q       <= 4'b0000;
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         base_tick_q  <= base_tick_d;
         state_q      <= state_d;
         ready_q      <= ready_d;
         cap_chan_q   <= cap_chan_d;
         cap_period_q <= cap_period_d;
         cap_mode_q   <= cap_mode_d;
         cap_enable_q <= cap_enable_d;
         per_q        <= per_d;
         cnt_q        <= cnt_d;
         mode_q       <= mode_d;
         busy_q       <= busy_d;
         tick_q       <= tick_d;
      end
   end

   assign CfgReady = ready_q;
   assign BaseTick = base_tick_q;
   assign Tick     = tick_q;
   assign Busy     = busy_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler with BASE_DIV=4. A behavioural model runs in
// lockstep and is compared every cycle; a table of configurations checks tick
// counts from a known phase; hand-written sequences cover deferral, reset
// during APPLY and disarming; a randomized phase closes out the run.

module tb_tick_scheduler;

   localparam int BD = 4;
   localparam int PB = 4;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          CfgValid = 1'b0;
   logic          CfgReady;
   logic [1:0]    CfgChan = 2'd0;
   logic [PB-1:0] CfgPeriod = '0;
   logic          CfgMode = 1'b0;
   logic          CfgEnable = 1'b0;
   logic          BaseTick;
   logic [3:0]    Tick;
   logic [3:0]    Busy;

   tick_scheduler #(.BASE_DIV(BD), .BASE_BITS(3), .PERIOD_BITS(PB)) dut (
      .Clock(Clock), .Reset(Reset), .CfgValid(CfgValid), .CfgReady(CfgReady),
      .CfgChan(CfgChan), .CfgPeriod(CfgPeriod), .CfgMode(CfgMode),
      .CfgEnable(CfgEnable), .BaseTick(BaseTick), .Tick(Tick), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   // Model state: cycles since reset, per-channel base ticks seen since write
   int       t;
   bit       m_bt, m_ready, pend, ack;
   bit [3:0] m_tick, m_busy;
   int       m_per[4];
   bit       m_mode[4];
   int       m_n[4];
   int       c_chan, c_per;
   bit       c_mode, c_en;
   int       tick_cnt[4];

   typedef struct {
      int ch; int per; bit mode; bit en; int cycles; int exp_ticks; bit exp_busy;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit bt_now, rdy_now;
      bit [3:0] tk;
      if (Reset) begin
         t = 0; m_bt = 0; m_tick = '0; m_busy = '0; m_ready = 0; pend = 0; ack = 0;
         for (int i = 0; i < 4; i++) begin m_per[i] = 0; m_mode[i] = 0; m_n[i] = 0; end
      end else begin
         bt_now = m_bt; rdy_now = m_ready; tk = '0;
         if (bt_now) begin
            for (int i = 0; i < 4; i++) begin
               if (m_busy[i]) begin
                  m_n[i]++;
                  if (m_n[i] % m_per[i] == 0) begin
                     tk[i] = 1'b1;
                     if (m_mode[i]) m_busy[i] = 1'b0;
                  end
               end
            end
         end
         if (rdy_now && CfgValid) begin
            c_chan = int'(CfgChan); c_per = int'(CfgPeriod); c_mode = CfgMode; c_en = CfgEnable;
            pend = 1; m_ready = 0;
         end else if (pend) begin
            if (!bt_now) begin
               m_per[c_chan] = c_per; m_mode[c_chan] = c_mode; m_n[c_chan] = 0;
               m_busy[c_chan] = c_en && (c_per != 0);
               pend = 0; ack = 1;
            end
            m_ready = 0;
         end else if (ack) begin
            ack = 0; m_ready = 1;
         end else begin
            m_ready = 1;
         end
         t++;
         m_bt = (t % BD == 0);
         m_tick = tk;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge Clock);
      #1;
      check("BaseTick", 32'(BaseTick), 32'(m_bt));
      check("Tick",     32'(Tick),     32'(m_tick));
      check("Busy",     32'(Busy),     32'(m_busy));
      check("CfgReady", 32'(CfgReady), 32'(m_ready));
      for (int i = 0; i < 4; i++) if (Tick[i] === 1'b1) tick_cnt[i]++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) tick_cnt[i] = 0;
   endtask

   // Two reset cycles, then the first edge with Reset low.
   task automatic do_reset();
      CfgValid = 1'b0;
      Reset = 1'b1;
      run(2);
      Reset = 1'b0;
      step();
   endtask

   // Wait (bounded) for ready, then present one request for one cycle.
   task automatic configure(input int ch, input int per, input bit mode, input bit en);
      int guard = 0;
      while (!m_ready && guard < 20) begin step(); guard++; end
      check("cfg_ready_wait", 32'(CfgReady), 32'd1);
      CfgChan = 2'(ch); CfgPeriod = PB'(per); CfgMode = mode; CfgEnable = en;
      CfgValid = 1'b1;
      step();
      CfgValid = 1'b0;
   endtask

   initial begin
      int k, low, others;

      vecs[0] = '{ch:0, per:3, mode:0, en:1, cycles:60, exp_ticks:5, exp_busy:1};
      vecs[1] = '{ch:2, per:2, mode:1, en:1, cycles:40, exp_ticks:1, exp_busy:0};
      vecs[2] = '{ch:1, per:0, mode:0, en:1, cycles:30, exp_ticks:0, exp_busy:0};
      vecs[3] = '{ch:3, per:1, mode:0, en:1, cycles:30, exp_ticks:7, exp_busy:1};
      vecs[4] = '{ch:3, per:1, mode:1, en:1, cycles:30, exp_ticks:1, exp_busy:0};
      vecs[5] = '{ch:0, per:5, mode:0, en:0, cycles:40, exp_ticks:0, exp_busy:0};
      vecs[6] = '{ch:1, per:4, mode:0, en:1, cycles:40, exp_ticks:2, exp_busy:1};

      // Free run: first BaseTick exactly 4 cycles after release
      do_reset();
      k = 1;
      while (BaseTick !== 1'b1 && k < 10) begin step(); k++; end
      check("first_basetick", 32'(k), 32'd4);
      run(16);

      // Table of configurations, each from a freshly reset phase
      foreach (vecs[v]) begin
         do_reset();
         configure(vecs[v].ch, vecs[v].per, vecs[v].mode, vecs[v].en);
         clear_counts();
         run(vecs[v].cycles);
         check($sformatf("tbl%0d_ticks", v), 32'(tick_cnt[vecs[v].ch]), 32'(vecs[v].exp_ticks));
         check($sformatf("tbl%0d_busy", v), 32'(Busy[vecs[v].ch]), 32'(vecs[v].exp_busy));
         others = 0;
         for (int i = 0; i < 4; i++) if (i != vecs[v].ch) others += tick_cnt[i];
         check($sformatf("tbl%0d_others", v), 32'(others), 32'd0);
      end

      // Deferred write: APPLY lands on a BaseTick cycle
      do_reset();
      configure(0, 1, 1'b0, 1'b1);
      k = 0;
      while (BaseTick !== 1'b1 && k < 10) begin step(); k++; end
      run(3);
      CfgChan = 2'd3; CfgPeriod = PB'(2); CfgMode = 1'b0; CfgEnable = 1'b1;
      CfgValid = 1'b1;
      step();
      CfgValid = 1'b0;
      check("defer_align", 32'(BaseTick), 32'd1);
      low = 0;
      while (CfgReady !== 1'b1 && low < 10) begin low++; step(); end
      check("defer_ready_low", 32'(low), 32'd3);
      clear_counts();
      run(40);
      check("defer_ch0_ticks", 32'(tick_cnt[0]), 32'd10);
      check("defer_ch3_ticks", 32'(tick_cnt[3]), 32'd5);

      // Reset while the FSM is in APPLY abandons the write
      do_reset();
      configure(2, 2, 1'b0, 1'b1);
      Reset = 1'b1;
      step();
      check("rst_apply_busy", 32'(Busy), 32'd0);
      check("rst_apply_ready", 32'(CfgReady), 32'd0);
      Reset = 1'b0;
      step();
      check("rst_release_ready", 32'(CfgReady), 32'd1);
      clear_counts();
      run(20);
      check("rst_apply_ticks", 32'(tick_cnt[2]), 32'd0);
      check("rst_apply_busy2", 32'(Busy[2]), 32'd0);

      // Period 0 stays disarmed; disarming a periodic channel stops it
      do_reset();
      configure(0, 2, 1'b0, 1'b1);
      run(20);
      configure(1, 0, 1'b0, 1'b1);
      run(4);
      check("p0_busy", 32'(Busy[1]), 32'd0);
      configure(0, 2, 1'b0, 1'b0);
      run(5);
      clear_counts();
      run(30);
      check("disarm_ticks", 32'(tick_cnt[0]), 32'd0);
      check("disarm_busy", 32'(Busy[0]), 32'd0);
      check("p0_ticks", 32'(tick_cnt[1]), 32'd0);

      // Randomized requests (including while not ready) and rare resets
      do_reset();
      for (int i = 0; i < 600; i++) begin
         CfgValid  = ($urandom_range(0, 2) == 0);
         CfgChan   = 2'($urandom_range(0, 3));
         CfgPeriod = PB'($urandom_range(0, 5));
         CfgMode   = 1'($urandom_range(0, 1));
         CfgEnable = ($urandom_range(0, 3) != 0);
         Reset     = ($urandom_range(0, 149) == 0);
         step();
      end
      Reset = 1'b0;
      CfgValid = 1'b0;
      run(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter BASE_DIV, default 100000, sets the base-tick period in Clock cycles (1 ms at 100 MHz); legal range 2 or more.
REQ-002 Parameter BASE_BITS, default 17, sets the prescaler counter width; it SHALL hold BASE_DIV-1.
REQ-003 Parameter PERIOD_BITS, default 10, sets the per-channel period and counter width.
REQ-004 Clock  in  1  system clock; all state updates on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 CfgValid  in  1  configuration request.
REQ-007 CfgReady  out  1  scheduler can accept a configuration.
REQ-008 CfgChan  in  2  target channel, 0..3.
REQ-009 CfgPeriod  in  PERIOD_BITS  channel period in base ticks.
REQ-010 CfgMode  in  1  0 = periodic, 1 = one-shot.
REQ-011 CfgEnable  in  1  1 = arm channel, 0 = disarm channel.
REQ-012 BaseTick  out  1  one-cycle pulse, once per BASE_DIV cycles.
REQ-013 Tick  out  4  per-channel one-cycle event pulses.
REQ-014 Busy  out  4  per-channel armed flags.

Function
REQ-015 The prescaler SHALL count 0..BASE_DIV-1 and wrap to 0; BaseTick SHALL be 1 in the cycle after the counter equals BASE_DIV-1, and 0 otherwise.
REQ-016 Each armed channel SHALL increment its counter only in cycles where BaseTick=1.
REQ-017 In a BaseTick=1 cycle where the channel counter equals Period-1, the channel SHALL clear its counter and drive Tick[ch]=1 in the next cycle, for exactly one cycle.
REQ-018 In one-shot mode, the cycle that schedules the tick SHALL also clear Busy[ch]; in periodic mode, Busy[ch] SHALL stay 1.
REQ-019 Period=1 SHALL tick on every base tick; Period=0 with CfgEnable=1 SHALL leave the channel disarmed (Busy=0, no ticks).
REQ-020 An unarmed channel SHALL hold its counter and SHALL never assert Tick.
REQ-021 The configuration FSM SHALL have three states: IDLE, APPLY and ACK.
REQ-022 In IDLE, CfgReady=1; when CfgValid=1, the FSM SHALL capture CfgChan, CfgPeriod, CfgMode and CfgEnable and move to APPLY.
REQ-023 In APPLY, CfgReady=0; if BaseTick=0, the FSM SHALL write the captured configuration and move to ACK; if BaseTick=1, it SHALL stay in APPLY, deferring the write by one cycle.
REQ-024 A write SHALL load period and mode, clear the channel counter to 0, and set Busy[ch] = CfgEnable AND (CfgPeriod != 0).
REQ-025 In ACK, CfgReady=0; the FSM SHALL return to IDLE in the next cycle.
REQ-026 With no deferral, acceptance at cycle n SHALL give a write at the edge ending n+1, updated Busy visible at n+2, and CfgReady=1 at n+3.
REQ-027 A write to a channel SHALL NOT disturb other channels or the prescaler.
REQ-028 A Tick pulse already registered SHALL still be emitted if that channel is reconfigured in the same cycle.
REQ-029 CfgValid while CfgReady=0 SHALL be ignored.
REQ-030 Channels SHALL be independent; any subset of Tick bits MAY assert in the same cycle.

Reset
REQ-031 While Reset=1: prescaler, all channel counters, periods and modes = 0; Busy = 4'b0000, Tick = 4'b0000, BaseTick = 0, CfgReady = 0, FSM = IDLE.
REQ-032 Reset asserted mid-configuration SHALL abandon the pending write; CfgReady=1 in the first cycle after Reset deasserts.
REQ-033 The prescaler SHALL restart from 0 after reset, so the first BaseTick occurs BASE_DIV cycles after deassertion.

Verification (BASE_DIV=4)
REQ-034 Free run after reset -> BaseTick every 4 cycles, first BaseTick 4 cycles after Reset deasserts, Tick=0, Busy=0.
REQ-035 Configure ch0 with Period=3, periodic, enable -> Busy[0]=1; Tick[0] every 12 cycles, one cycle after every third BaseTick.
REQ-036 Configure ch2 with Period=2, one-shot -> exactly one Tick[2] pulse, Busy[2] falls when the tick is scheduled, and no further ticks over 40 cycles.
REQ-037 CfgValid accepted so that APPLY coincides with BaseTick=1 -> write deferred one cycle, CfgReady low for 3 cycles, no lost or duplicate Tick on other channels.
REQ-038 Configure ch1 with Period=0 and enable -> Busy[1]=0 and no Tick[1]; then disable periodic ch0 -> Tick[0] stops and Busy[0]=0.
REQ-039 Assert Reset while in APPLY -> all outputs 0, the captured configuration is not applied, CfgReady=1 one cycle after release.
